// File: rtl/instr_mem_pkg.sv
// Shared types and constants for the instruction memory server.
package instr_mem_pkg;

  localparam int unsigned INSTR_W_DEF = 14;
  localparam int unsigned PC_W_DEF    = 8;
  localparam int unsigned DEPTH_DEF   = 64;

  localparam logic [INSTR_W_DEF-1:0] FILL_INSTR = 14'h0000;
  localparam int unsigned            PC_STRIDE  = 4;

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    IDLE = 2'd1,
    READ = 2'd2,
    RESP = 2'd3
  } state_t;

endpackage

// File: rtl/instr_mem_array.sv
// Instruction storage: one write port, one synchronous read port, per-entry
// valid bits cleared asynchronously by clr_i. Contents are never reset.
// Optional second read port (prefetch) when INSTR_MEM_PREFETCH_EN is defined.
module instr_mem_array #(
  parameter int unsigned INSTR_W = 14,
  parameter int unsigned DEPTH   = 64,
  parameter int unsigned AW      = $clog2(DEPTH)
) (
  input  logic               clk_i,
  input  logic               clr_i,
  input  logic               we_i,
  input  logic [AW-1:0]      waddr_i,
  input  logic [INSTR_W-1:0] wdata_i,
  input  logic [AW-1:0]      raddr_i,
  output logic [INSTR_W-1:0] rdata_o,
  output logic               rvalid_o
`ifdef INSTR_MEM_PREFETCH_EN
  ,
  input  logic               pf_re_i,
  input  logic [AW-1:0]      pf_raddr_i,
  output logic [INSTR_W-1:0] pf_rdata_o,
  output logic               pf_rvalid_o
`endif
);

  logic [INSTR_W-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0]   valid_q;

  // Storage write and registered read; no reset on contents.
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    rdata_o  <= mem_q[raddr_i];
    rvalid_o <= valid_q[raddr_i];
  end

  // Entry-valid bits: set on write, cleared by clr_i.
  always_ff @(posedge clk_i or posedge clr_i) begin
    if (clr_i) valid_q <= '0;
    else if (we_i) valid_q[waddr_i] <= 1'b1;
  end

`ifdef INSTR_MEM_PREFETCH_EN
  // Prefetch read port; holds its word between enabled reads.
  always_ff @(posedge clk_i) begin
    if (pf_re_i) begin
      pf_rdata_o  <= mem_q[pf_raddr_i];
      pf_rvalid_o <= valid_q[pf_raddr_i];
    end
  end
`endif

endmodule

// File: rtl/instr_mem_server.sv
// Instruction memory server: host loads the program, core fetches 14-bit
// words by byte PC. Optional macro INSTR_MEM_PREFETCH_EN adds a one-entry
// prefetch register (pc+4) giving latency-1 responses on a tag hit.
module instr_mem_server
  import instr_mem_pkg::*;
#(
  parameter int unsigned INSTR_W = INSTR_W_DEF,
  parameter int unsigned PC_W    = PC_W_DEF,
  parameter int unsigned DEPTH   = DEPTH_DEF
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               load_valid,
  output logic               load_ready,
  input  logic [5:0]         load_addr,
  input  logic [INSTR_W-1:0] load_data,
  input  logic               load_done,
  input  logic               reload_req,
  input  logic               fetch_req,
  input  logic [PC_W-1:0]    fetch_pc,
  output logic               fetch_ready,
  output logic               instr_valid,
  output logic [INSTR_W-1:0] instruction,
  output logic               fetch_fault,
  output logic               prog_loaded
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [INSTR_W-1:0] FILL = INSTR_W'(FILL_INSTR);
  localparam logic [PC_W-1:0]    STRIDE = PC_W'(PC_STRIDE);

  state_t             state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic               pend_q, pend_d;
  logic               loaded_q, loaded_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic               src_pf_q, src_pf_d;

  logic [INSTR_W-1:0] rd_data;
  logic               rd_vld;
  logic [INSTR_W-1:0] src_data;
  logic               src_vld;
  logic               resp_fault;
  logic [INSTR_W-1:0] resp_word;
  logic               hit;
  logic [PC_W-1:0]    pc_next;

  assign pc_next = pc_q + STRIDE;

`ifdef INSTR_MEM_PREFETCH_EN
  logic [PC_W-1:0]    tag_q, tag_d;
  logic               tag_vld_q, tag_vld_d;
  logic [INSTR_W-1:0] pf_data;
  logic               pf_vld;
  logic               pf_re;
  assign pf_re = (state_q == RESP);
  assign hit   = tag_vld_q && (fetch_pc == tag_q);
`else
  assign hit = 1'b0;
`endif

  instr_mem_array #(
    .INSTR_W (INSTR_W),
    .DEPTH   (DEPTH),
    .AW      (AW)
  ) u_array (
    .clk_i      (clock),
    .clr_i      (reset),
    .we_i       ((state_q == LOAD) && load_valid),
    .waddr_i    (load_addr[AW-1:0]),
    .wdata_i    (load_data),
    .raddr_i    (pc_q[AW+1:2]),
    .rdata_o    (rd_data),
    .rvalid_o   (rd_vld)
`ifdef INSTR_MEM_PREFETCH_EN
    ,
    .pf_re_i    (pf_re),
    .pf_raddr_i (pc_next[AW+1:2]),
    .pf_rdata_o (pf_data),
    .pf_rvalid_o(pf_vld)
`endif
  );

  // Response word source: prefetch register on a tag hit, array port otherwise.
  always_comb begin
    src_data = rd_data;
    src_vld  = rd_vld;
`ifdef INSTR_MEM_PREFETCH_EN
    if (src_pf_q) begin
      src_data = pf_data;
      src_vld  = pf_vld;
    end
`endif
    resp_fault = (pc_q[1:0] != 2'b00) || !src_vld;
    resp_word  = resp_fault ? FILL : src_data;
  end

  // State and datapath registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= LOAD;
      pc_q      <= '0;
      pend_q    <= 1'b0;
      loaded_q  <= 1'b0;
      instr_q   <= FILL;
      src_pf_q  <= 1'b0;
`ifdef INSTR_MEM_PREFETCH_EN
      tag_q     <= '0;
      tag_vld_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      pend_q    <= pend_d;
      loaded_q  <= loaded_d;
      instr_q   <= instr_d;
      src_pf_q  <= src_pf_d;
`ifdef INSTR_MEM_PREFETCH_EN
      tag_q     <= tag_d;
      tag_vld_q <= tag_vld_d;
`endif
    end
  end

  // Next-state and register updates.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    pend_d   = pend_q;
    loaded_d = loaded_q;
    src_pf_d = src_pf_q;
    instr_d  = (state_q == RESP) ? resp_word : instr_q;
    unique case (state_q)
      LOAD: if (load_done) state_d = IDLE;
      IDLE: begin
        if (reload_req) begin
          state_d = LOAD;
        end else if (fetch_req) begin
          pc_d     = fetch_pc;
          src_pf_d = hit;
          state_d  = hit ? RESP : READ;
        end
      end
      READ: begin
        state_d = RESP;
        if (reload_req) pend_d = 1'b1;
      end
      RESP: begin
        state_d = (pend_q || reload_req) ? LOAD : IDLE;
        pend_d  = 1'b0;
      end
      default: state_d = LOAD;
    endcase
    if (state_q == LOAD && load_done) loaded_d = 1'b1;
    else if (state_q != LOAD && state_d == LOAD) loaded_d = 1'b0;
`ifdef INSTR_MEM_PREFETCH_EN
    tag_d     = tag_q;
    tag_vld_d = tag_vld_q;
    if (state_q == RESP && state_d == IDLE) begin
      tag_d     = pc_next;
      tag_vld_d = 1'b1;
    end
    if ((state_q == LOAD && load_valid) || state_d == LOAD) tag_vld_d = 1'b0;
`endif
  end

  // Outputs decoded from state; instruction holds the last response.
  always_comb begin
    load_ready  = (state_q == LOAD);
    fetch_ready = (state_q == IDLE);
    instr_valid = (state_q == RESP);
    fetch_fault = (state_q == RESP) && resp_fault;
    instruction = (state_q == RESP) ? resp_word : instr_q;
    prog_loaded = loaded_q;
  end

endmodule

// File: tb/tb_instr_mem_server.sv
// Self-checking bench for instr_mem_server with a scoreboard of expected
// responses and a reference model of memory, valid bits and prefetch tag.
module tb_instr_mem_server;

`ifdef INSTR_MEM_PREFETCH_EN
  localparam bit PF = 1'b1;
`else
  localparam bit PF = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset;
  logic        load_valid, load_ready, load_done, reload_req;
  logic [5:0]  load_addr;
  logic [13:0] load_data;
  logic        fetch_req, fetch_ready, instr_valid, fetch_fault, prog_loaded;
  logic [7:0]  fetch_pc;
  logic [13:0] instruction;

  instr_mem_server #(.INSTR_W(14), .PC_W(8), .DEPTH(64)) dut (
    .clock(clock), .reset(reset),
    .load_valid(load_valid), .load_ready(load_ready), .load_addr(load_addr),
    .load_data(load_data), .load_done(load_done), .reload_req(reload_req),
    .fetch_req(fetch_req), .fetch_pc(fetch_pc), .fetch_ready(fetch_ready),
    .instr_valid(instr_valid), .instruction(instruction),
    .fetch_fault(fetch_fault), .prog_loaded(prog_loaded)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [13:0] instr;
    logic        fault;
    int unsigned lat;
  } exp_t;

  exp_t        sb[$];
  int          n_cmp = 0;
  int          n_err = 0;
  logic [13:0] m_mem [64];
  logic        m_vld [64];
  bit          tag_v = 1'b0;
  logic [7:0]  tag = '0;

  task automatic push_expect(input logic [7:0] pc);
    exp_t e;
    logic [5:0] idx;
    idx = pc[7:2];
    e.fault = (pc[1:0] != 2'b00) || !m_vld[idx];
    e.instr = e.fault ? 14'h0000 : m_mem[idx];
    e.lat   = (PF && tag_v && tag == pc) ? 1 : 2;
    sb.push_back(e);
  endtask

  task automatic cyc();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic load_word(input logic [5:0] idx, input logic [13:0] d, input logic done);
    load_valid = 1'b1; load_addr = idx; load_data = d; load_done = done;
    cyc();
    load_valid = 1'b0; load_done = 1'b0;
    m_mem[idx] = d; m_vld[idx] = 1'b1; tag_v = 1'b0;
  endtask

  task automatic finish_load();
    load_done = 1'b1;
    cyc();
    load_done = 1'b0;
    n_cmp++;
    if (prog_loaded !== 1'b1 || fetch_ready !== 1'b1) begin
      n_err++;
      $display("FAIL load_done: prog_loaded=%b fetch_ready=%b, required 1/1", prog_loaded, fetch_ready);
    end
  endtask

  task automatic reload_idle();
    reload_req = 1'b1;
    cyc();
    reload_req = 1'b0;
    tag_v = 1'b0;
    n_cmp++;
    if (load_ready !== 1'b1 || prog_loaded !== 1'b0) begin
      n_err++;
      $display("FAIL reload_idle: load_ready=%b prog_loaded=%b, required 1/0", load_ready, prog_loaded);
    end
  endtask

  // Full fetch: accept, wait (bounded) for the response, compare, check the pulse ends.
  task automatic do_fetch(input logic [7:0] pc, input bit reload_in_read);
    exp_t e;
    int unsigned lat;
    n_cmp++;
    if (fetch_ready !== 1'b1) begin
      n_err++;
      $display("FAIL fetch_ready pc=%h: got %b, required 1", pc, fetch_ready);
    end
    push_expect(pc);
    fetch_req = 1'b1; fetch_pc = pc;
    cyc();
    fetch_req = 1'b0;
    lat = 1;
    if (reload_in_read) reload_req = 1'b1;
    while (!instr_valid && lat < 8) begin
      cyc();
      reload_req = 1'b0;
      lat++;
    end
    reload_req = 1'b0;
    e = sb.pop_front();
    n_cmp++;
    if (!instr_valid) begin
      n_err++;
      $display("FAIL resp_timeout pc=%h: instr_valid never rose within %0d cycles", pc, lat);
    end else if (instruction !== e.instr || fetch_fault !== e.fault || lat != e.lat) begin
      n_err++;
      $display("FAIL resp pc=%h: instr=%h fault=%b lat=%0d, required instr=%h fault=%b lat=%0d",
               pc, instruction, fetch_fault, lat, e.instr, e.fault, e.lat);
    end
    if (!reload_in_read) begin
      tag = pc + 8'd4;
      tag_v = 1'b1;
    end else begin
      tag_v = 1'b0;
    end
    cyc();
    n_cmp++;
    if (instr_valid !== 1'b0 || instruction !== e.instr) begin
      n_err++;
      $display("FAIL resp_hold pc=%h: valid=%b instr=%h, required 0/%h", pc, instr_valid, instruction, e.instr);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; load_valid = 0; load_addr = '0; load_data = '0; load_done = 0;
    reload_req = 0; fetch_req = 0; fetch_pc = '0;
    for (int unsigned i = 0; i < 64; i++) begin m_mem[i] = 'x; m_vld[i] = 1'b0; end
    repeat (2) @(negedge clock);
    n_cmp++;
    if (load_ready !== 1'b1 || fetch_ready !== 1'b0 || instr_valid !== 1'b0 ||
        instruction !== 14'h0000 || fetch_fault !== 1'b0 || prog_loaded !== 1'b0) begin
      n_err++;
      $display("FAIL reset_state: lr=%b fr=%b iv=%b ins=%h ff=%b pl=%b, required 1 0 0 0000 0 0",
               load_ready, fetch_ready, instr_valid, instruction, fetch_fault, prog_loaded);
    end
    reset = 1'b0;
    cyc();
  endtask

  task automatic test_basic();
    load_word(6'd0, 14'h0A11, 1'b0);
    load_word(6'd1, 14'h1234, 1'b0);
    finish_load();
    do_fetch(8'h00, 1'b0);
    do_fetch(8'h04, 1'b0);
    // write attempted outside LOAD must not land
    load_valid = 1'b1; load_addr = 6'd5; load_data = 14'h3555;
    cyc();
    load_valid = 1'b0;
    do_fetch(8'h14, 1'b0);
  endtask

  task automatic test_faults();
    do_fetch(8'h06, 1'b0);
    do_fetch(8'h08, 1'b0);
  endtask

  task automatic test_reload();
    do_fetch(8'h04, 1'b1);
    n_cmp++;
    if (load_ready !== 1'b1 || prog_loaded !== 1'b0 || fetch_ready !== 1'b0) begin
      n_err++;
      $display("FAIL reload_pending: lr=%b pl=%b fr=%b, required 1 0 0", load_ready, prog_loaded, fetch_ready);
    end
    // write and done in the same cycle
    load_word(6'd2, 14'h0222, 1'b1);
    n_cmp++;
    if (fetch_ready !== 1'b1 || prog_loaded !== 1'b1) begin
      n_err++;
      $display("FAIL write_with_done: fr=%b pl=%b, required 1 1", fetch_ready, prog_loaded);
    end
    do_fetch(8'h08, 1'b0);
  endtask

  task automatic test_prefetch();
    reload_idle();
    finish_load();
    do_fetch(8'h00, 1'b0);
    do_fetch(8'h04, 1'b0);
    reload_idle();
    finish_load();
    do_fetch(8'h04, 1'b0);
  endtask

  task automatic test_reset_mid();
    exp_t e;
    int unsigned lat;
    push_expect(8'h00);
    fetch_req = 1'b1; fetch_pc = 8'h00;
    cyc();
    fetch_req = 1'b0;
    lat = 1;
    while (!instr_valid && lat < 8) begin cyc(); lat++; end
    e = sb.pop_front();
    n_cmp++;
    if (!instr_valid || instruction !== e.instr || lat != e.lat) begin
      n_err++;
      $display("FAIL pre_reset_resp: iv=%b instr=%h lat=%0d, required 1 %h %0d",
               instr_valid, instruction, lat, e.instr, e.lat);
    end
    #1 reset = 1'b1;
    #1;
    n_cmp++;
    if (instr_valid !== 1'b0 || load_ready !== 1'b1 || instruction !== 14'h0000 || fetch_fault !== 1'b0) begin
      n_err++;
      $display("FAIL reset_in_resp: iv=%b lr=%b ins=%h ff=%b, required 0 1 0000 0",
               instr_valid, load_ready, instruction, fetch_fault);
    end
    for (int unsigned i = 0; i < 64; i++) m_vld[i] = 1'b0;
    tag_v = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    cyc();
    finish_load();
    do_fetch(8'h00, 1'b0);
  endtask

  task automatic test_wrap();
    reload_idle();
    load_word(6'd63, 14'h3F3F, 1'b0);
    finish_load();
    do_fetch(8'hFC, 1'b0);
    do_fetch(8'h00, 1'b0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_faults();
    test_reload();
    test_prefetch();
    test_reset_mid();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
